// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive front end.
// Holds the deframer state enum, the legal oversampling ratios, the default
// data width, and the helper that maps any Prescale value onto a legal ratio.
package uart_rx_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   // Anything other than 16 or 32 behaves as 8x oversampling.
   function automatic logic [5:0] legal_prescale(input logic [5:0] p);
      logic [5:0] r;
      case (p)
         PRESCALE_16: r = PRESCALE_16;
         PRESCALE_32: r = PRESCALE_32;
         default:     r = PRESCALE_8;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit timing and 3-sample majority voter.
// Ports: clk_i/rst_i; active_i (frame in progress), data_phase_i (data bits
// being shifted), rx_s_i (synced line), prescale_i (latched ratio);
// outputs sampled_bit_o, bit_done_o (last oversample tick of a bit),
// last_bit_o (current data bit is the final one).
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       active_i,
   input  logic       data_phase_i,
   input  logic       rx_s_i,
   input  logic [5:0] prescale_i,
   output logic       sampled_bit_o,
   output logic       bit_done_o,
   output logic       last_bit_o
);

   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [5:0]     edge_cnt_q, edge_cnt_d;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]     smp_q, smp_d;
   logic [5:0]     half;

   assign half = prescale_i >> 1;

   assign bit_done_o    = active_i && (edge_cnt_q == (prescale_i - 6'd1));
   assign last_bit_o    = (bit_cnt_q == BCW'(DATA_WIDTH - 1));
   assign sampled_bit_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) |
                          (smp_q[1] & smp_q[2]);

   always_comb begin
      // edge_cnt sits at 0 while idle so the start-detection cycle is tick 0.
      edge_cnt_d = '0;
      if (active_i && !bit_done_o) begin
         edge_cnt_d = edge_cnt_q + 6'd1;
      end

      smp_d = smp_q;
      if (active_i) begin
         if (edge_cnt_q == (half - 6'd1)) smp_d[0] = rx_s_i;
         if (edge_cnt_q == half)          smp_d[1] = rx_s_i;
         if (edge_cnt_q == (half + 6'd1)) smp_d[2] = rx_s_i;
      end

      bit_cnt_d = bit_cnt_q;
      if (!data_phase_i) begin
         bit_cnt_d = '0;
      end else if (bit_done_o) begin
         bit_cnt_d = last_bit_o ? '0 : bit_cnt_q + BCW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
         smp_q      <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         smp_q      <= smp_d;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive deframer feeding the clock-domain data synchronizer.
// Ports: CLK/RST (async high); RX_IN serial line; PAR_EN/PAR_TYP/Prescale framing
// config (latched at start); P_DATA last good byte, data_valid 1-cycle strobe,
// par_err/stp_err error flags of the most recent frame.
module uart_rx_frame
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            Prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   rx_state_e             state_q, state_d;
   logic [1:0]            sync_q;
   logic                  rx_s;
   logic [5:0]            prescale_q;
   logic                  par_en_q, par_typ_q;
   logic                  cfg_load;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;
   logic                  sampled_bit, bit_done, last_bit;

   assign rx_s = sync_q[1];

   uart_rx_sampler #(.DATA_WIDTH(DATA_WIDTH)) u_sampler (
      .clk_i         (CLK),
      .rst_i         (RST),
      .active_i      (state_q != IDLE),
      .data_phase_i  (state_q == DATA),
      .rx_s_i        (rx_s),
      .prescale_i    (prescale_q),
      .sampled_bit_o (sampled_bit),
      .bit_done_o    (bit_done),
      .last_bit_o    (last_bit)
   );

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      par_err_d    = par_err_q;
      stp_err_d    = stp_err_q;
      cfg_load     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d   = START;
               cfg_load  = 1'b1;
               par_err_d = 1'b0;
               stp_err_d = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               if (sampled_bit) begin
                  state_d = IDLE;
               end else begin
                  // A back-to-back start skips IDLE, so the previous
                  // frame's flags are dropped once this start is confirmed.
                  state_d   = DATA;
                  par_err_d = 1'b0;
                  stp_err_d = 1'b0;
               end
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
               if (last_bit) begin
                  state_d = par_en_q ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               if (sampled_bit != ((^shift_q) ^ par_typ_q)) begin
                  par_err_d = 1'b1;
               end
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_done) begin
               stp_err_d = !sampled_bit;
               if (!par_err_q && sampled_bit) begin
                  p_data_d     = shift_q;
                  data_valid_d = 1'b1;
               end
               // The line already shows the next bit here; low means a new frame.
               if (!rx_s) begin
                  state_d  = START;
                  cfg_load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q       <= 2'b11;
         state_q      <= IDLE;
         prescale_q   <= PRESCALE_8;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         shift_q      <= '0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         sync_q       <= {sync_q[0], RX_IN};
         state_q      <= state_d;
         shift_q      <= shift_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
         if (cfg_load) begin
            prescale_q <= legal_prescale(Prescale);
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
         end
      end
   end

   assign P_DATA     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stp_err    = stp_err_q;

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receive front end of the UART clock domain. It oversamples the asynchronous RX line, deframes start/data/parity/stop bits, and presents one parallel byte with a single-cycle valid pulse. This is the stage that feeds the data synchronizer carrying the byte into the system clock domain: P_DATA drives its unsync_bus, and data_valid drives its bus_enable. A bit-level framing error must never reach the synchronizer as valid data.

## Interface
- DATA_WIDTH, 8, data bits per frame, LSB first on the line
- CLK  in  1  UART oversampling clock
- RST  in  1  asynchronous, active-high reset
- RX_IN  in  1  serial line, idle high, asynchronous to CLK
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = even, 1 = odd
- Prescale  in  6  oversampling ratio; 8, 16 and 32 legal, any other value treated as 8
- P_DATA  out  DATA_WIDTH  last good byte
- data_valid  out  1  one-cycle pulse, P_DATA new and error-free
- par_err  out  1  parity mismatch on the most recent frame
- stp_err  out  1  stop bit sampled 0 on the most recent frame

## Operation
- RX_IN passes through an internal 2-flop synchronizer, reset value 1; all logic uses the synced line (rx_s).
- Reset values: P_DATA = 0, data_valid = 0, par_err = 0, stp_err = 0, FSM = IDLE, counters = 0.
- PAR_EN, PAR_TYP and Prescale are latched on start detection; changes mid-frame do not affect the current frame.
- Counters: edge_cnt runs 0..Prescale-1 once per bit; bit_cnt counts data bits 0..DATA_WIDTH-1.
- Each bit value is the majority of 3 samples, taken at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
- FSM states and transitions:
  - IDLE: rx_s = 0 -> START, with edge_cnt = 0 on this cycle. par_err and stp_err clear here.
  - START: at edge_cnt = Prescale-1, a sampled 1 (glitch) -> IDLE with no outputs; a sampled 0 -> DATA.
  - DATA: shift the sampled bit into the shift register LSB-first. After bit DATA_WIDTH-1, go to PARITY if PAR_EN, else STOP.
  - PARITY: compare the sample with the XOR of the data bits (inverted when PAR_TYP = 1). On mismatch, set par_err. Then -> STOP.
  - STOP: set stp_err if the sample is 0. At edge_cnt = Prescale-1:
    - if par_err and stp_err are both clear, load P_DATA and pulse data_valid;
    - then -> START if rx_s = 0 on that cycle (back-to-back frame), else IDLE.
- Error flags hold until the next start detection.
- P_DATA holds its value until the next good frame and is never updated on an errored frame.

## Timing
- Cycle 0 = first CLK edge with rx_s = 0 in IDLE; rx_s lags RX_IN by 2 edges.
- P = PAR_EN. Frame length is (10+P)*Prescale cycles.
- data_valid is high on exactly cycle (10+P)*Prescale for exactly 1 cycle; P_DATA changes on the same edge.
- par_err is visible from cycle (10)*Prescale when PAR_EN = 1.
- stp_err is visible on cycle (10+P)*Prescale.
- Back-to-back frames: no idle gap is required, and a new start is accepted on the final stop cycle.
- RST asserted mid-frame: all outputs and state return to reset values immediately. After release, the block waits for a fresh falling edge; a line already low at release counts as a start.
- A line stuck low after a stop error: re-enters START, receives the next frame as a 0x00 frame that fails its stop check, and data_valid stays low.

## Structure
- Package uart_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the legal prescale constants (8, 16, 32);
  - the default DATA_WIDTH.
- Sub-module uart_rx_sampler: edge/bit counters plus the 3-sample majority voter. It outputs sampled_bit and a bit_done strobe.
- Top level: synchronizer, FSM, shift register, parity check, output registers.

## Test plan
- Prescale = 8, PAR_EN = 0, send 0xA5 -> data_valid single pulse at cycle 80 after start detection, P_DATA = 0xA5, both error flags 0.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 0, send 0x3C with parity bit 0 -> P_DATA = 0x3C, data_valid at cycle 176. Repeat with parity bit 1 -> par_err = 1, no data_valid, P_DATA stays 0x3C.
- Prescale = 32, odd parity, send 0x81 with stop bit 0 -> stp_err = 1, data_valid never asserted.
- 1-cycle low glitch on RX_IN (Prescale = 8) -> FSM returns to IDLE, no outputs change.
- Two frames 0x11 and 0xEE back-to-back with no idle gap at Prescale = 8 -> two data_valid pulses exactly 80 cycles apart, P_DATA 0x11 then 0xEE.
- RST pulsed during data bit 4 -> all outputs 0. A following clean frame 0x5A -> received correctly.
